// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM state type and byte-merge helper for the cache
package cache_pkg;

  localparam int ADR_W  = 30;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEMREAD  = 2'd1,
    MEMWRITE = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Replace only the byte lanes selected by be; other lanes keep old_word.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] new_word,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] result;
    result = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/cache_array.sv
// rtl/cache_array.sv - valid/tag/data storage: combinational lookup, masked synchronous write
import cache_pkg::*;

module cache_array #(
  parameter int LINES   = 256,
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_word,
  input  logic               wr_en,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_word,
  input  logic [BE_W-1:0]    wr_be,
  input  logic               clr_en
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] words [LINES];

  assign rd_valid = valid[index];
  assign rd_tag   = tags[index];
  assign rd_word  = words[index];

  // Valid bits: cleared on reset, clear request beats a write to the same line.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (clr_en) begin
      valid[index] <= 1'b0;
    end else if (wr_en) begin
      valid[index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; a line is meaningless until its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[index]  <= wr_tag;
      words[index] <= byte_merge(words[index], wr_word, wr_be);
    end
  end

endmodule

// File: rtl/cache.sv
// rtl/cache.sv - direct-mapped write-through cache; optional CACHE_INVALIDATE_EN adds invalidate input
import cache_pkg::*;

module cache #(
  parameter int LINES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADR_W-1:0]  adr,
  inout  wire  [DATA_W-1:0] data,
  input  logic [BE_W-1:0]   byteen,
  input  logic              rwb,
  input  logic              en,
`ifdef CACHE_INVALIDATE_EN
  input  logic              invalidate,
`endif
  output logic              done,
  output logic [ADR_W-1:0]  memadr,
  inout  wire  [DATA_W-1:0] memdata,
  output logic [BE_W-1:0]   membyteen,
  output logic              memrwb,
  output logic              memen,
  input  logic              memdone
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = ADR_W - INDEX_W;

  state_t             state, next_state;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_word;
  logic               hit;
  logic               inv;
  logic               wr_req, clr_req, capture, drive_data;
  logic [BE_W-1:0]    wr_be;
  logic [DATA_W-1:0]  wr_word;
  logic [DATA_W-1:0]  rdata_q;

`ifdef CACHE_INVALIDATE_EN
  assign inv = invalidate;
`else
  assign inv = 1'b0;
`endif

  assign index = adr[INDEX_W-1:0];
  assign tag   = adr[ADR_W-1:INDEX_W];
  assign hit   = rd_valid && (rd_tag == tag);

  // A hit is returned straight from the array; a miss returns the word captured from memory.
  assign data    = drive_data ? ((state == DONE) ? rdata_q : rd_word) : 'z;
  assign memdata = (memen && !memrwb) ? data : 'z;
  assign memadr  = adr;
  assign wr_word = (state == MEMWRITE) ? data : memdata;

  cache_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .index    (index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_word  (rd_word),
    .wr_en    (wr_req && !reset),
    .wr_tag   (tag),
    .wr_word  (wr_word),
    .wr_be    (wr_be),
    .clr_en   (clr_req && !reset)
  );

  // State register; reset abandons any memory access in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Holds the memory word of a read miss for the DONE cycle.
  always_ff @(posedge clk) begin
    if (capture) rdata_q <= memdata;
  end

  // Next-state, handshake outputs and array update controls.
  always_comb begin
    next_state = state;
    done       = 1'b0;
    memen      = 1'b0;
    memrwb     = 1'b1;
    membyteen  = {BE_W{1'b1}};
    wr_req     = 1'b0;
    clr_req    = 1'b0;
    wr_be      = {BE_W{1'b1}};
    capture    = 1'b0;
    drive_data = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          if (rwb) begin
            if (hit && !inv) begin
              done       = 1'b1;
              drive_data = 1'b1;
            end else begin
              next_state = MEMREAD;
            end
          end else begin
            next_state = MEMWRITE;
          end
        end
      end
      MEMREAD: begin
        memen = 1'b1;
        if (memdone) begin
          next_state = DONE;
          capture    = 1'b1;
          if (inv) clr_req = 1'b1;
          else     wr_req  = 1'b1;
        end
      end
      MEMWRITE: begin
        memen     = 1'b1;
        memrwb    = 1'b0;
        membyteen = byteen;
        if (memdone) begin
          next_state = DONE;
          wr_be      = byteen;
          if (inv) begin
            clr_req = 1'b1;
          end else if (hit || (byteen == {BE_W{1'b1}})) begin
            wr_req = 1'b1;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        drive_data = en && rwb;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache.sv
// tb/tb_cache.sv - directed scoreboard bench for the cache
module tb_cache;

  logic        clk = 1'b0;
  logic        reset, en, rwb, memdone;
  logic [29:0] adr;
  logic [3:0]  byteen;
  logic [31:0] wdata, mem_word;
  wire  [31:0] data, memdata;
  wire         done, memrwb, memen;
  wire  [29:0] memadr;
  wire  [3:0]  membyteen;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  bit          mvalid [256];
  logic [21:0] mtag   [256];
  logic [31:0] mword  [256];

  always #5 clk = ~clk;

  assign data    = (en && !rwb) ? wdata : 'z;
  assign memdata = (en && rwb) ? mem_word : 'z;

  cache dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .data      (data),
    .byteen    (byteen),
    .rwb       (rwb),
    .en        (en),
`ifdef CACHE_INVALIDATE_EN
    .invalidate(1'b0),
`endif
    .done      (done),
    .memadr    (memadr),
    .memdata   (memdata),
    .membyteen (membyteen),
    .memrwb    (memrwb),
    .memen     (memen),
    .memdone   (memdone)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
  endtask

  task automatic do_req(input logic r, input logic [29:0] a, input logic [31:0] w,
                        input logic [3:0] be, input int wait_n, input logic [31:0] mw);
    int          idx;
    logic [21:0] t;
    bit          hit;
    int          cnt;
    bit          got;
    logic [31:0] merged;
    idx = int'(a[7:0]);
    t   = a[29:8];
    hit = mvalid[idx] && (mtag[idx] == t);
    if (r) sb.push_back(hit ? mword[idx] : mw);
    @(posedge clk); #1;
    adr = a; rwb = r; wdata = w; byteen = be; mem_word = mw; memdone = 1'b0; en = 1'b1;
    cnt = 0;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      #1;
      if (done) begin
        got = 1'b1;
        if (r) check("read_data", data, sb.pop_front());
        check("memen_cycles", cnt, (r && hit) ? 0 : wait_n + 1);
        check("memen_at_done", {31'b0, memen}, 32'd0);
      end else if (memen) begin
        cnt++;
        check("memrwb", {31'b0, memrwb}, {31'b0, r});
        check("memadr", {2'b0, memadr}, {2'b0, a});
        check("membyteen", {28'b0, membyteen}, {28'b0, (r ? 4'hf : be)});
        if (!r) check("memdata", memdata, w);
        memdone = (cnt > wait_n);
      end
      if (!got) begin
        @(posedge clk); #1;
      end
    end
    check("done_seen", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    en = 1'b0; memdone = 1'b0;
    #1;
    check("done_pulse", {31'b0, done}, 32'd0);
    if (r && !hit) begin
      mvalid[idx] = 1'b1; mtag[idx] = t; mword[idx] = mw;
    end else if (!r) begin
      if (hit) begin
        merged = mword[idx];
        for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = w[8*b +: 8];
        mword[idx] = merged;
      end else if (be == 4'hf) begin
        mvalid[idx] = 1'b1; mtag[idx] = t; mword[idx] = w;
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; rwb = 1'b1; memdone = 1'b0;
    adr = '0; byteen = 4'hf; wdata = '0; mem_word = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_memen", {31'b0, memen}, 32'd0);
    check("reset_memrwb", {31'b0, memrwb}, 32'd1);
    reset = 1'b0;

    // memdone while idle must not start anything
    @(posedge clk); #1;
    memdone = 1'b1;
    @(posedge clk); #1;
    check("idle_memdone_memen", {31'b0, memen}, 32'd0);
    check("idle_memdone_done", {31'b0, done}, 32'd0);
    memdone = 1'b0;

    do_req(1'b1, 30'h0, 32'h0, 4'hf, 0, 32'h0000_0000);
    do_req(1'b0, 30'h0, 32'hDEAD_BEEF, 4'hf, 0, 32'h0);
    do_req(1'b1, 30'h0, 32'h0, 4'hf, 0, 32'hAAAA_AAAA);
    do_req(1'b0, 30'h2000_0000, 32'hAABB_CCDD, 4'b1011, 0, 32'h0);
    do_req(1'b1, 30'h0, 32'h0, 4'hf, 0, 32'h5555_5555);
    do_req(1'b1, 30'h100, 32'h0, 4'hf, 3, 32'h1234_5678);
    do_req(1'b1, 30'h100, 32'h0, 4'hf, 0, 32'h0BAD_0BAD);
    do_req(1'b0, 30'h100, 32'h0000_9900, 4'b0010, 1, 32'h0);
    do_req(1'b1, 30'h100, 32'h0, 4'hf, 0, 32'h0BAD_0BAD);
    do_req(1'b0, 30'h3, 32'h1122_3344, 4'hf, 2, 32'h0);
    do_req(1'b1, 30'h3, 32'h0, 4'hf, 0, 32'h0BAD_0BAD);
    do_req(1'b1, 30'h0, 32'h0, 4'hf, 0, 32'h0BAD_0BAD);

    // reset in the middle of a read miss
    @(posedge clk); #1;
    adr = 30'h55; rwb = 1'b1; en = 1'b1; mem_word = 32'h0; memdone = 1'b0;
    @(posedge clk); #1;
    check("midread_memen", {31'b0, memen}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_memen", {31'b0, memen}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    reset = 1'b0; en = 1'b0;
    model_reset();
    do_req(1'b1, 30'h55, 32'h0, 4'hf, 1, 32'hCAFE_F00D);
    do_req(1'b1, 30'h100, 32'h0, 4'hf, 0, 32'h1111_0000);
    do_req(1'b1, 30'h55, 32'h0, 4'hf, 0, 32'h0BAD_0BAD);

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
